approx_mult_pipe: RTL and testbench
===================================

APPROX_MULT_PIPE -- requirements
Module: approx_mult_pipe

Interface
REQ-001 Parameter W, default 8, SHALL set operand width (legal 4..16).
REQ-002 Parameter K, default 4, SHALL set the count of approximated low result columns (legal 0..2W-1).
REQ-003 Port clk, input, 1, SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1, SHALL be a synchronous, active-high reset.
REQ-005 Port in_valid, input, 1, SHALL indicate that an operand pair is offered.
REQ-006 Port in_ready, output, 1, SHALL indicate that the block accepts the offered pair this cycle.
REQ-007 Ports in_a and in_b, input, W each, SHALL be the unsigned operands.
REQ-008 Port in_mode, input, 1, SHALL select the mode: 0 = exact, 1 = approximate.
REQ-009 Port out_valid, output, 1, SHALL indicate that a result is presented.
REQ-010 Port out_ready, input, 1, SHALL indicate that the consumer takes the result this cycle.
REQ-011 Port out_p, output, 2W, SHALL be the product.
REQ-012 Port out_mode, output, 1, SHALL echo in_mode of the same transaction.
REQ-013 Port approx_cnt, output, 16, SHALL count completed approximate transactions.

Function
REQ-014 Input handshake SHALL occur when in_valid && in_ready; output handshake SHALL occur when out_valid && out_ready.
REQ-015 The block SHALL be a 3-stage pipeline: S1 registers operands and mode; S2 registers per-column reduced partial products; S3 registers the final sum.
REQ-016 Latency SHALL be exactly 3 cycles from input handshake to out_valid when unstalled; throughput SHALL be 1 transaction per cycle.
REQ-017 Each stage SHALL advance when it is empty or the next stage advances; in_ready SHALL equal (S1 empty || S1 advances), so a bubble can be filled while out_ready is low.
REQ-018 Out_ready low SHALL stall the pipeline without loss, duplication or reordering; the pipeline SHALL hold at most 3 transactions.
REQ-019 out_p, out_mode and out_valid SHALL hold stable while out_valid && !out_ready.
REQ-020 Partial product pp[i][j] SHALL equal in_a[j] & in_b[i]; column c SHALL hold all pp with i+j = c.
REQ-021 Exact mode: out_p SHALL equal in_a*in_b modulo 2^(2W).
REQ-022 Approximate mode: for column c<K, result bit c SHALL be the OR of column c, with no carry generated; columns c>=K SHALL be summed exactly with carries, receiving no carry from columns below K.
REQ-023 K=0 SHALL make the approximate result identical to the exact result.
REQ-024 approx_cnt SHALL increment on each output handshake with out_mode=1 and SHALL saturate at 0xFFFF.
REQ-025 Simultaneous input and output handshakes SHALL both take effect in the same cycle.

Reset
REQ-026 On rst, all stage-valid flags, out_valid, out_p, out_mode and approx_cnt SHALL be 0 on the next edge; in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-027 rst mid-operation SHALL discard all in-flight transactions; none SHALL emerge afterwards.

Structure
REQ-028 Package approx_mult_pkg SHALL hold the mode enum (MODE_EXACT, MODE_APPROX), the defaults for W and K, and the counter width of 16.
REQ-029 The column reduction SHALL be the sub-module approx_col_reduce: combinational, parameterised by column height, outputting the OR-reduced or exact column count as selected by mode.

Verification (W=8, K=4)
REQ-030 Exact 0xFF*0xFF -> out_p=0xFE01 after 3 cycles, out_mode=0.
REQ-031 Approx 0xFF*0xFF -> out_p=0xFDDF; approx 0x03*0x03 -> 0x0007; approx 0x00*0xA5 -> 0x0000; approx_cnt=3.
REQ-032 out_ready held low for 6 cycles while 5 back-to-back pairs are offered -> exactly 3 accepted, in_ready low thereafter; on release all 5 delivered in order with correct values.
REQ-033 rst asserted with 3 transactions in flight -> no out_valid afterwards, approx_cnt=0, in_ready=1.
REQ-034 K=0, 1000 random approx pairs -> out_p equals a*b for every pair.
REQ-035 70000 approximate transactions -> approx_cnt stops at 0xFFFF.

Source files
------------

// File: rtl/approx_mult_pkg.sv
// Shared types and defaults for the approximate multiplier pipeline.
package approx_mult_pkg;

  typedef enum logic {
    MODE_EXACT  = 1'b0,
    MODE_APPROX = 1'b1
  } mode_e;

  localparam int DEF_W = 8;
  localparam int DEF_K = 4;
  localparam int CNT_W = 16;

  // Number of partial products landing in column c of a w x w array.
  function automatic int col_height(int w, int c);
    return (c < w) ? c + 1 : 2 * w - 1 - c;
  endfunction

endpackage

// File: rtl/approx_col_reduce.sv
// Reduces one partial-product column to either its population count
// (exact) or a single OR bit (approximate, never carries).
module approx_col_reduce #(
  parameter int H  = 1,
  parameter int OW = 1
) (
  input  logic [H-1:0]  bits_i,
  input  logic          approx_i,
  output logic [OW-1:0] sum_o
);

  logic [OW-1:0] cnt;

  always_comb begin
    cnt = '0;
    for (int k = 0; k < H; k++) cnt = cnt + OW'(bits_i[k]);
    sum_o = approx_i ? OW'(|bits_i) : cnt;
  end

endmodule

// File: rtl/approx_mult_pipe.sv
// 3-stage unsigned multiplier with an optional carry-free approximation of
// the K lowest result columns, plus a saturating approximate-result counter.
module approx_mult_pipe
  import approx_mult_pkg::*;
#(
  parameter int W = DEF_W,
  parameter int K = DEF_K
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   out_p,
  output logic             out_mode,
  output logic [CNT_W-1:0] approx_cnt
);

  localparam int PW   = 2 * W;
  localparam int NCOL = 2 * W - 1;
  localparam int CW   = $clog2(W + 1);

  logic [3:1] vld_q;
  logic [3:1] en;

  logic [W-1:0]  a_q, b_q;
  mode_e         m1_q, m2_q, m3_q;
  logic [NCOL-1:0][CW-1:0] col_d, col_q;
  logic [PW-1:0] sum_d, p_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  // A stage may load when empty or when its occupant moves on this cycle.
  assign en[3]     = !vld_q[3] || out_ready;
  assign en[2]     = !vld_q[2] || en[3];
  assign en[1]     = !vld_q[1] || en[2];
  assign in_ready  = en[1];
  assign out_valid = vld_q[3];
  assign out_p     = p_q;
  assign out_mode  = m3_q;
  assign approx_cnt = cnt_q;

  for (genvar c = 0; c < NCOL; c++) begin : g_col
    localparam int H  = col_height(W, c);
    localparam int LO = (c < W) ? 0 : c - W + 1;
    logic [H-1:0] bits;
    for (genvar k = 0; k < H; k++) begin : g_pp
      assign bits[k] = a_q[LO+k] & b_q[c-LO-k];
    end
    approx_col_reduce #(.H(H), .OW(CW)) u_red (
      .bits_i  (bits),
      .approx_i(m1_q == MODE_APPROX && (c < K)),
      .sum_o   (col_d[c])
    );
  end

  // Low approximated columns are single bits, so no carry can leave them.
  always_comb begin
    sum_d = '0;
    for (int c = 0; c < NCOL; c++) sum_d = sum_d + (PW'(col_q[c]) << c);
  end

  always_comb begin
    cnt_d = cnt_q;
    if (out_valid && out_ready && m3_q == MODE_APPROX && cnt_q != '1)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      m1_q  <= MODE_EXACT;
      m2_q  <= MODE_EXACT;
      m3_q  <= MODE_EXACT;
      col_q <= '0;
      p_q   <= '0;
      cnt_q <= '0;
    end else begin
      if (en[1]) begin
        vld_q[1] <= in_valid;
        a_q      <= in_a;
        b_q      <= in_b;
        m1_q     <= mode_e'(in_mode);
      end
      if (en[2]) begin
        vld_q[2] <= vld_q[1];
        col_q    <= col_d;
        m2_q     <= m1_q;
      end
      if (en[3]) begin
        vld_q[3] <= vld_q[2];
        p_q      <= sum_d;
        m3_q     <= m2_q;
      end
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_approx_mult_pipe.sv
// Directed + randomized bench for approx_mult_pipe (K=4 and K=0 instances).
module tb_approx_mult_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_mode = 1'b0, out_ready = 1'b0;
  logic [7:0]  in_a = '0, in_b = '0;

  logic        rdy4, ov4, om4, rdy0, ov0, om0;
  logic [15:0] p4, p0, cnt4, cnt0;

  always #5 clk = ~clk;

  approx_mult_pipe #(.W(8), .K(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy4),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .out_valid(ov4),
    .out_ready(out_ready), .out_p(p4), .out_mode(om4), .approx_cnt(cnt4));

  approx_mult_pipe #(.W(8), .K(0)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .out_valid(ov0),
    .out_ready(out_ready), .out_p(p0), .out_mode(om0), .approx_cnt(cnt0));

  typedef struct {
    logic [15:0] p4;
    logic [15:0] p0;
    logic        m;
  } exp_t;

  exp_t        q[$];
  logic [15:0] got[$];
  int n_assert = 0, n_fail = 0;
  int exp_cnt = 0, n_acc = 0, n_del = 0, n_apx = 0;
  bit fired, hold_vld;
  logic [15:0] hold_p;
  logic        hold_m;

  // Product as the rules describe it: columns below k contribute only an OR bit.
  function automatic logic [15:0] model(logic [7:0] a, logic [7:0] b, logic m, int k);
    int hi, lo;
    if (!m) return 16'(int'(a) * int'(b));
    hi = 0; lo = 0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        if (a[j] && b[i]) begin
          if (i + j < k) lo = lo | (1 << (i + j));
          else           hi = hi + (1 << (i + j));
        end
    return 16'(hi + lo);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit v, input logic [7:0] a, input logic [7:0] b,
                      input bit m, input bit ordy);
    exp_t e;
    @(negedge clk);
    in_valid = v; in_a = a; in_b = b; in_mode = m; out_ready = ordy;
    #1;
    fired = 1'b0;
    chk("approx_cnt", cnt4, exp_cnt);
    chk("approx_cnt_k0", cnt0, exp_cnt);
    chk("in_ready_k0", rdy0, rdy4);
    if (hold_vld) begin
      chk("hold_out_p", p4, hold_p);
      chk("hold_out_mode", om4, hold_m);
      chk("hold_out_valid", ov4, 1'b1);
    end
    hold_vld = ov4 && !ordy;
    hold_p = p4; hold_m = om4;
    if (ov4 && ordy) begin
      fired = 1'b1;
      if (q.size() == 0) chk("spurious_out_valid", ov4, 1'b0);
      else begin
        e = q.pop_front();
        chk("out_p", p4, e.p4);
        chk("out_p_k0", p0, e.p0);
        chk("out_mode", om4, e.m);
        chk("out_valid_k0", ov0, 1'b1);
        chk("out_mode_k0", om0, e.m);
        got.push_back(p4);
        n_del++;
        if (e.m && exp_cnt < 65535) exp_cnt++;
      end
    end
    if (v && rdy4) begin
      q.push_back('{model(a, b, m, 4), model(a, b, m, 0), m});
      n_acc++;
      if (m) n_apx++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    q.delete(); exp_cnt = 0; hold_vld = 1'b0;
    #1;
    chk("rst_out_valid", ov4, 1'b0);
    chk("rst_out_p", p4, 16'h0);
    chk("rst_out_mode", om4, 1'b0);
    chk("rst_approx_cnt", cnt4, 16'h0);
    chk("rst_in_ready", rdy4, 1'b1);
  endtask

  initial begin
    logic [7:0] pa[6], pb[6];
    bit pm[6];
    int idx, lat, base, guard, seen;

    do_reset();

    // Latency and exact corner
    step(1, 8'hFF, 8'hFF, 0, 1);
    lat = 0;
    do begin step(0, 8'h00, 8'h00, 0, 1); lat++; end while (!fired && lat < 10);
    chk("latency", lat, 3);
    chk("exact_ff_ff", got[got.size()-1], 16'hFE01);

    // Approximate directed values
    got.delete();
    step(1, 8'hFF, 8'hFF, 1, 1);
    step(1, 8'h03, 8'h03, 1, 1);
    step(1, 8'h00, 8'hA5, 1, 1);
    repeat (5) step(0, 8'h00, 8'h00, 0, 1);
    chk("approx_ff_ff", got[0], 16'hFDDF);
    chk("approx_03_03", got[1], 16'h0007);
    chk("approx_00_a5", got[2], 16'h0000);
    chk("approx_cnt_3", cnt4, 16'd3);

    // Stall with 5 offered pairs
    for (int i = 0; i < 6; i++) begin
      pa[i] = 8'($urandom); pb[i] = 8'($urandom); pm[i] = 1'($urandom_range(0, 1));
    end
    idx = 0; base = n_del;
    for (int c = 0; c < 6; c++) begin
      seen = n_acc;
      step(idx < 5, pa[idx], pb[idx], pm[idx], 0);
      if (n_acc != seen) idx++;
    end
    chk("stall_accepted", idx, 3);
    chk("stall_in_ready", rdy4, 1'b0);
    guard = 0;
    while ((idx < 5 || q.size() != 0) && guard < 50) begin
      seen = n_acc;
      step(idx < 5, pa[idx], pb[idx], pm[idx], 1);
      if (n_acc != seen) idx++;
      guard++;
    end
    chk("stall_delivered", n_del - base, 5);

    // Random traffic with random stalls until 1000 approximate pairs accepted
    base = n_apx; guard = 0;
    while (n_apx - base < 1000 && guard < 6000) begin
      step($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom),
           $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
      guard++;
    end
    chk("random_approx_count", (n_apx - base >= 1000), 1'b1);
    guard = 0;
    while (q.size() != 0 && guard < 50) begin step(0, 8'h00, 8'h00, 0, 1); guard++; end
    chk("random_drained", q.size(), 0);

    // Reset with three transactions in flight
    repeat (3) step(1, 8'($urandom), 8'($urandom), 1, 0);
    do_reset();
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      step(0, 8'h00, 8'h00, 0, 1);
      if (ov4 || ov0) seen++;
    end
    chk("flush_no_output", seen, 0);
    chk("flush_approx_cnt", cnt4, 16'h0);

    // Counter saturation
    for (int c = 0; c < 70000; c++) step(1, 8'($urandom), 8'($urandom), 1, 1);
    repeat (5) step(0, 8'h00, 8'h00, 0, 1);
    chk("cnt_saturated", cnt4, 16'hFFFF);
    chk("cnt_saturated_k0", cnt0, 16'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
